// File: rtl/uart_receiver.sv
// uart_receiver: 8E1 UART receiver with a 16x oversampling tick generator and sticky error flags
// Ports: clk; reset (async, active-high); baud_select (3-bit baud code); Rx_EN (enable);
//        RxD (serial in, idles high); Rx_DATA (last good byte); Rx_VALID (1-clk good-frame strobe);
//        Rx_PERROR / Rx_FERROR (sticky parity / framing error, cleared at start detection)
module uart_receiver #(
   parameter int CLK_HZ     = 50000000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);
   function automatic int div_for(input int baud);
      return (CLK_HZ + OVERSAMPLE * baud / 2) / (OVERSAMPLE * baud);
   endfunction
   localparam int DIV [8] = '{div_for(300), div_for(1200), div_for(4800), div_for(9600),
                              div_for(19200), div_for(38400), div_for(57600), div_for(115200)};
   localparam int TW = $clog2(DIV[0] + 1);
   localparam int SW = $clog2(OVERSAMPLE);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t          r_state, w_next;
   logic [1:0]      r_sync;
   logic            r_rx_d;
   logic [2:0]      r_baud;
   logic [TW-1:0]   r_tick_cnt;
   logic [SW-1:0]   r_smp_cnt;
   logic [2:0]      r_bit_cnt;
   logic [7:0]      r_shift;
   logic            w_rx, w_start, w_tick, w_smp, w_load, w_perr, w_ferr;
   assign w_rx    = r_sync[1];
   assign w_start = Rx_EN && r_state == IDLE && r_rx_d && !w_rx;
   assign w_tick  = r_tick_cnt == TW'(DIV[r_baud] - 1);
   // START samples after half a bit to land mid-bit; every later bit is a full bit further on
   assign w_smp   = Rx_EN && w_tick &&
                    r_smp_cnt == SW'(r_state == START ? OVERSAMPLE / 2 - 1 : OVERSAMPLE - 1);
   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_start ? START : IDLE;
         START:   if (w_smp) w_next = w_rx ? IDLE : DATA;
         DATA:    if (w_smp && r_bit_cnt == 3'd7) w_next = PARITY;
         PARITY:  if (w_smp) w_next = STOP;
         STOP:    if (w_smp) w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (!Rx_EN) w_next = IDLE;
   end
   always_comb begin
      w_perr = r_state == PARITY && w_smp && (^r_shift ^ w_rx);
      w_ferr = r_state == STOP && w_smp && !w_rx;
      // Rx_PERROR already reflects this frame because it was cleared at start detection
      w_load = r_state == STOP && w_smp && w_rx && !Rx_PERROR;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_sync     <= 2'b11;
         r_rx_d     <= 1'b1;
         r_baud     <= '0;
         r_tick_cnt <= '0;
         r_smp_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         Rx_DATA    <= '0;
         Rx_VALID   <= 1'b0;
         Rx_PERROR  <= 1'b0;
         Rx_FERROR  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], RxD};
         r_rx_d     <= w_rx;
         // held at 0 in IDLE so the first tick of a frame is phase-aligned to the start edge
         r_tick_cnt <= (r_state == IDLE || w_tick) ? '0 : r_tick_cnt + 1'b1;
         r_smp_cnt  <= (r_state == IDLE || w_smp) ? '0 : (w_tick ? r_smp_cnt + 1'b1 : r_smp_cnt);
         r_bit_cnt  <= r_state == IDLE ? '0 : r_bit_cnt + 3'(r_state == DATA && w_smp);
         if (r_state == DATA && w_smp) r_shift <= {w_rx, r_shift[7:1]};
         if (w_start) begin
            r_baud    <= baud_select;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
         end else begin
            if (w_perr) Rx_PERROR <= 1'b1;
            if (w_ferr) Rx_FERROR <= 1'b1;
         end
         Rx_VALID <= w_load;
         if (w_load) Rx_DATA <= r_shift;
      end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames on RxD checked against hand-computed bytes, flags and latency
`timescale 1ns/1ps
module tb_uart_receiver;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       Rx_EN = 1'b1;
   logic       RxD = 1'b1;
   logic [2:0] baud_select = 3'b111;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_PERROR, Rx_FERROR;
   int         n_chk = 0, n_fail = 0, n_valid = 0, cyc = 0, valid_cyc = 0, start_cyc = 0, lat = 0;
   uart_receiver dut (
      .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN), .RxD(RxD),
      .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
   );
   always #10 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk)
      if (Rx_VALID) begin
         n_valid++;
         valid_cyc = cyc;
      end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // kind at bit ev: 1 = drop Rx_EN, 2 = 100 ns reset pulse, 3 = switch baud_select to 000
   task automatic send(input logic [7:0] d, input logic pflip, input logic stopb,
                       input int bit_ns, input int ev, input int kind);
      logic [10:0] f;
      f = {stopb, ^d ^ pflip, d, 1'b0};
      @(negedge clk);
      n_valid = 0;
      start_cyc = cyc;
      for (int i = 0; i < 11; i++) begin
         RxD = f[i];
         if (i == ev) begin
            #(bit_ns / 2);
            if (kind == 1) Rx_EN = 1'b0;
            else if (kind == 2) begin
               reset = 1'b1;
               #100;
               reset = 1'b0;
            end else baud_select = 3'b000;
            #(bit_ns - bit_ns / 2 - (kind == 2 ? 100 : 0));
         end else #(bit_ns);
      end
      RxD = 1'b1;
      #(bit_ns);
      lat = valid_cyc - start_cyc;
   endtask
   initial begin
      #390;
      chk("rst_data", Rx_DATA, 8'h00);
      chk("rst_valid", Rx_VALID, 1'b0);
      chk("rst_perr", Rx_PERROR, 1'b0);
      chk("rst_ferr", Rx_FERROR, 1'b0);
      #10 reset = 1'b0;
      #200000;
      chk("idle_strobes", n_valid, 0);
      chk("idle_data", Rx_DATA, 8'h00);
      chk("idle_flags", {Rx_PERROR, Rx_FERROR}, 2'b00);
      send(8'h9A, 1'b0, 1'b1, 8640, -1, 0);
      chk("9a_strobes", n_valid, 1);
      chk("9a_data", Rx_DATA, 8'h9A);
      chk("9a_flags", {Rx_PERROR, Rx_FERROR}, 2'b00);
      chk("9a_latency_in_4536pm27", lat >= 4509 && lat <= 4563, 1'b1);
      send(8'h9A, 1'b1, 1'b1, 8640, -1, 0);
      chk("par_perr", Rx_PERROR, 1'b1);
      chk("par_ferr", Rx_FERROR, 1'b0);
      chk("par_strobes", n_valid, 0);
      chk("par_data", Rx_DATA, 8'h9A);
      send(8'h55, 1'b0, 1'b1, 8640, -1, 0);
      chk("55_strobes", n_valid, 1);
      chk("55_data", Rx_DATA, 8'h55);
      chk("55_perr", Rx_PERROR, 1'b0);
      send(8'h3C, 1'b0, 1'b0, 8640, -1, 0);
      chk("stop_ferr", Rx_FERROR, 1'b1);
      chk("stop_perr", Rx_PERROR, 1'b0);
      chk("stop_strobes", n_valid, 0);
      chk("stop_data", Rx_DATA, 8'h55);
      @(negedge clk);
      n_valid = 0;
      RxD = 1'b0;
      #80 RxD = 1'b1;
      #8640;
      chk("glitch_flags", {Rx_PERROR, Rx_FERROR}, 2'b00);
      chk("glitch_strobes", n_valid, 0);
      send(8'hA5, 1'b0, 1'b1, 8640, -1, 0);
      chk("a5_strobes", n_valid, 1);
      chk("a5_data", Rx_DATA, 8'hA5);
      @(negedge clk);
      n_valid = 0;
      RxD = 1'b0;
      #(12 * 8640);
      RxD = 1'b1;
      #8640;
      chk("break_ferr", Rx_FERROR, 1'b1);
      chk("break_perr", Rx_PERROR, 1'b0);
      chk("break_strobes", n_valid, 0);
      send(8'hF0, 1'b0, 1'b1, 8640, -1, 0);
      chk("f0_strobes", n_valid, 1);
      chk("f0_data", Rx_DATA, 8'hF0);
      chk("f0_ferr", Rx_FERROR, 1'b0);
      send(8'hC3, 1'b0, 1'b1, 8640, 4, 1);
      Rx_EN = 1'b1;
      chk("en_strobes", n_valid, 0);
      chk("en_data", Rx_DATA, 8'hF0);
      chk("en_flags", {Rx_PERROR, Rx_FERROR}, 2'b00);
      send(8'h3C, 1'b0, 1'b1, 8640, -1, 0);
      chk("3c_strobes", n_valid, 1);
      chk("3c_data", Rx_DATA, 8'h3C);
      send(8'hF8, 1'b0, 1'b1, 8640, 5, 2);
      chk("rstmid_strobes", n_valid, 0);
      chk("rstmid_data", Rx_DATA, 8'h00);
      chk("rstmid_flags", {Rx_PERROR, Rx_FERROR}, 2'b00);
      send(8'h81, 1'b0, 1'b1, 8640, -1, 0);
      chk("81_strobes", n_valid, 1);
      chk("81_data", Rx_DATA, 8'h81);
      send(8'h6B, 1'b0, 1'b1, 8640, 2, 3);
      chk("latch_strobes", n_valid, 1);
      chk("latch_data", Rx_DATA, 8'h6B);
      baud_select = 3'b110;
      send(8'hC3, 1'b0, 1'b1, 17360, -1, 0);
      chk("57k6_strobes", n_valid, 1);
      chk("57k6_data", Rx_DATA, 8'hC3);
      chk("57k6_flags", {Rx_PERROR, Rx_FERROR}, 2'b00);
      chk("57k6_latency_in_9072pm54", lat >= 9018 && lat <= 9126, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel stage downstream of uart_transmitter. It consumes the TxD line as RxD and recovers 8-bit frames of the form start(0), D0..D7 LSB first, even parity, stop(1). Baud selection uses the same 3-bit code as the transmitter, and the block contains its own 16x oversampling tick generator. Each received byte is presented with a one-cycle valid strobe and sticky error flags.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- OVERSAMPLE, 16, sample ticks per bit.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- baud_select, input, 3, baud code: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- Rx_EN, input, 1, receiver enable.
- RxD, input, 1, serial line; idles high.
- Rx_DATA, output, 8, last good byte.
- Rx_VALID, output, 1, one-clock strobe for a good frame.
- Rx_PERROR, output, 1, parity error flag.
- Rx_FERROR, output, 1, framing error flag.

Behaviour:
- Reset values:
  - Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0, Rx_FERROR=0.
  - State IDLE; tick counter and sample counter at 0.
  - Synchronizer flops set to 1.
- RxD passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick generator:
  - divisor = round(CLK_HZ/(16*baud)). At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - Produces a 1-clk sample_tick every divisor clocks.
  - Counter restarts at 0 on start-edge detection so sampling phase aligns to the edge.
- baud_select is latched at start detection. Changes mid-frame have no effect until the next frame.
- States and transitions:
  - IDLE: when Rx_EN=1 and the synchronized line goes 1->0, clear both error flags, latch baud, go to START.
  - START: after 8 ticks (mid-bit), sample. If 0, go to DATA. If 1 (glitch/false start), return to IDLE with no flags set.
  - DATA: sample every 16 ticks at mid-bit. Shift LSB first into the shift register. After 8 bits, go to PARITY.
  - PARITY: sample after 16 ticks. Error if XOR(D7..D0, parity bit) is not 0 (even parity). Go to STOP.
  - STOP: sample after 16 ticks.
    - If the stop bit is 0: Rx_FERROR=1.
    - If no error at all: Rx_DATA<=shift register and Rx_VALID=1 for exactly one clk, in the clock after the stop sample.
    - If any error: Rx_VALID stays 0 and Rx_DATA is unchanged.
    - Go to IDLE immediately, so a back-to-back start edge half a bit later is caught.
- Error flags: Rx_PERROR and Rx_FERROR are sticky. They hold until the next start detection or reset, and both may be set together.
- Rx_EN=0:
  - In IDLE, no start is detected.
  - Mid-frame, abort to IDLE on the next clk with no strobe and no flag change.
  - Rx_DATA holds.
- Line held low (break): FERROR is set at the stop sample. The block then stays in IDLE until it sees a high, followed by a new 1->0 edge.
- Latency: Rx_VALID rises about 10.5 bit times plus 2 synchronizer clks after the start edge on RxD. At 115200 / 50 MHz this is 4536 clks, tolerance ±27.
- Reset mid-frame: immediate return to reset values; no strobe is produced.

Test Plan:
- Reset held 400 ns, then release with RxD=1 and Rx_EN=1 -> all outputs stay 0 and no Rx_VALID for 200 us.
- baud_select=111, drive frame 0x9A (bits LSB first 0,1,0,1,1,0,0,1; parity 0; stop 1) at 8640 ns/bit -> one 1-clk Rx_VALID about 4536 clks after the start edge, Rx_DATA=0x9A, both flags 0.
- Same frame with parity bit 1 -> Rx_PERROR=1, Rx_VALID never asserts, Rx_DATA still 0x9A. The next good frame 0x55 clears the flag and outputs 0x55.
- Stop bit driven 0 -> Rx_FERROR=1 and no strobe. A 4-clk (80 ns) low glitch on an idle line -> false start, no flags, back to IDLE.
- Loopback: uart_transmitter TxD to RxD, both at baud_select=011 (9600). Send 0x00, 0xFF, 0xA5 back-to-back -> three strobes carrying 0x00, 0xFF, 0xA5 with no flags. Repeat at 000 (300) for 0xC3.
- Drop Rx_EN during bit D3, or assert reset mid-frame -> receiver aborts, no strobe, Rx_DATA unchanged (reset case: Rx_DATA=0). The receiver resyncs on the following frame.
